// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per accepted start, with
// byte-lane steering, load extension, and misalign/illegal/timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a_lo;
  logic [2:0]       f3;

  logic             legal;
  logic             misal;
  logic [3:0]       be;
  logic [31:0]      lane;
  logic [31:0]      shifted;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  // Decode the incoming request: legality, alignment, byte enables, store lanes
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    be    = 4'b1111;
    lane  = wdata;
    if (is_store) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr[1:0];
        lane  = {2{wdata[15:0]}};
        misal = addr[0];
      end
      default: begin
        be    = 4'b1111;
        lane  = wdata;
        misal = (addr[1:0] != 2'b00);
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    shifted  = mem_rdata >> 5'({a_lo, 3'b000});
    byte_sel = shifted[7:0];
    half_sel = a_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_lo        <= '0;
      f3          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      fault       <= 1'b0;
      fault_cause <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!legal || misal) begin
              state       <= S_FIN;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= legal ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
            end else begin
              state     <= S_REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= lane;
              a_lo      <= addr[1:0];
              f3        <= funct3;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            if (mem_we) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req     <= 1'b0;
            state       <= S_FIN;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rdata <= load_ext;
            state <= S_FIN;
            done  <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state       <= S_FIN;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns at cycle 1 of the access
  task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    rst_n = 1'b1;
    tick();

    // LB at 0x1003, sign-extend top byte
    mem_rdata = 32'h80FF_1234;
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_req", 32'(mem_req), 32'd1);
    check("lb_be", 32'(mem_be), 32'h8);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_we", 32'(mem_we), 32'd0);
    check("lb_busy", 32'(busy), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("lb_req_drop", 32'(mem_req), 32'd0);
    check("lb_done_early", 32'(done), 32'd0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("lb_done", 32'(done), 32'd1);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_fault", 32'(fault), 32'd0);
    tick();
    check("lb_idle_done", 32'(done), 32'd0);
    check("lb_idle_busy", 32'(busy), 32'd0);

    // SH at 0x2002 with grant delayed three cycles
    issue(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
    check("sh_req", 32'(mem_req), 32'd1);
    check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sh_req_held", 32'(mem_req), 32'd1);
      check("sh_no_done", 32'(done), 32'd0);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sh_done", 32'(done), 32'd1);
    check("sh_fault", 32'(fault), 32'd0);
    check("sh_req_drop", 32'(mem_req), 32'd0);
    tick();

    // Misaligned LW
    issue(1'b0, 3'b010, 32'h0000_0001, 32'h0);
    check("mis_done", 32'(done), 32'd1);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_cause", 32'(fault_cause), 32'd1);
    check("mis_req", 32'(mem_req), 32'd0);
    tick();
    check("mis_after", 32'(done), 32'd0);

    // Illegal store funct3
    issue(1'b1, 3'b011, 32'h0000_0000, 32'h0);
    check("ill_done", 32'(done), 32'd1);
    check("ill_cause", 32'(fault_cause), 32'd3);
    check("ill_req", 32'(mem_req), 32'd0);
    tick();

    // Illegal load funct3 at a misaligned address: illegal wins
    issue(1'b0, 3'b110, 32'h0000_0003, 32'h0);
    check("pri_cause", 32'(fault_cause), 32'd3);
    tick();
    // Store with funct3 100 is illegal even though loads accept it
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    check("sb_u_cause", 32'(fault_cause), 32'd3);
    tick();

    // Load timeout in WAIT; rdata keeps the LB result
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", 32'(done), 32'd0);
    tick();
    check("to_done", 32'(done), 32'd1);
    check("to_fault", 32'(fault), 32'd1);
    check("to_cause", 32'(fault_cause), 32'd2);
    check("to_rdata", rdata, 32'hFFFF_FF80);
    tick();
    check("to_clear_cause", 32'(fault_cause), 32'd0);

    // Grant arriving on the expiry cycle wins
    issue(1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
    for (int i = 0; i < 15; i++) tick();
    check("ge_req", 32'(mem_req), 32'd1);
    check("ge_wdata", mem_wdata, 32'h1234_5678);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("ge_done", 32'(done), 32'd1);
    check("ge_fault", 32'(fault), 32'd0);
    tick();

    // LHU at 0x6; start and rvalid pulsed while in REQ are ignored
    issue(1'b0, 3'b101, 32'h0000_0006, 32'h0);
    start = 1'b1; funct3 = 3'b111; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    start = 1'b0; mem_rvalid = 1'b0;
    check("ign_req", 32'(mem_req), 32'd1);
    check("ign_done", 32'(done), 32'd0);
    check("ign_be", 32'(mem_be), 32'hC);
    mem_gnt = 1'b1; mem_rdata = 32'h9ABC_0000;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("lhu_done", 32'(done), 32'd1);
    check("lhu_rdata", rdata, 32'h0000_9ABC);
    check("lhu_fault", 32'(fault), 32'd0);
    tick();
    check("lhu_idle", 32'(busy), 32'd0);

    // Reset while in REQ drops the request immediately
    issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rreq_req", 32'(mem_req), 32'd0);
    check("rreq_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset while in WAIT
    issue(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rw_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_req", 32'(mem_req), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_done", 32'(done), 32'd0);
    check("rw_rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("rw_no_done", 32'(done), 32'd0);

    // SB at 0x5 after reset completes normally
    issue(1'b1, 3'b000, 32'h0000_0005, 32'h0000_00A5);
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_be", 32'(mem_be), 32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_addr", mem_addr, 32'h0000_0004);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sb_done", 32'(done), 32'd1);
    check("sb_fault", 32'(fault), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
